// File: rtl/serial_bit_feeder_pkg.sv
// Shared types and defaults for the serial bit feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package feeder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } feeder_state_t;

  localparam int   FEEDER_DEFAULT_WIDTH = 8;
  localparam logic FEEDER_IDLE_BIT      = 1'b0;

endpackage

// File: rtl/serial_bit_feeder_if.sv
// Parallel word handshake between a word source and the serial bit feeder.
// Latency: n/a (wires only).
// Backpressure: source holds data_in/data_valid until data_ready is seen high at an edge.
interface serial_bit_feeder_if
  import feeder_pkg::*;
#(
  parameter int WIDTH = FEEDER_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/serial_bit_feeder_hold_reg.sv
// One-entry holding register between the handshake and the shifter.
// Latency: word visible on dout and full set the edge after load.
// Backpressure: full stays high until take; caller must not load while full.
module feeder_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  // Capture on load, release on take; the two never share an edge because
  // load is only possible while the register is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      dout <= '0;
    end else begin
      if (take) begin
        full <= 1'b0;
      end
      if (load) begin
        full <= 1'b1;
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: shifts accepted words out on x, one bit per enabled clock.
// Latency: first bit on x the cycle after the edge following the handshake; gapless between words.
// Backpressure: data_ready low while the holding register is full; en=0 freezes the shifter and x.
module serial_bit_feeder
  import feeder_pkg::*;
#(
  parameter int   WIDTH     = FEEDER_DEFAULT_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = FEEDER_IDLE_BIT
) (
  input  logic              clk,
  input  logic              rst,
  serial_bit_feeder_if.slave up,
  input  logic              en,
  output logic              x,
  output logic              x_valid,
  output logic              word_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  feeder_state_t    state;
  logic [WIDTH-1:0] shf;
  logic [CW-1:0]    cnt;

  logic             hold_full;
  logic [WIDTH-1:0] hold_dat;
  logic             ready;
  logic             accept;
  logic             take;
  logic             last;
  logic [WIDTH-1:0] shifted;

  // Move the next bit toward the output end of the shifter.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      shift_one = {v[WIDTH-2:0], 1'b0};
    end else begin
      shift_one = {1'b0, v[WIDTH-1:1]};
    end
  endfunction

  // Bit currently presented at the output end of a shifter value.
  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    out_bit = MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Ready follows reset release combinationally so the source sees it immediately.
  assign ready         = rst & ~hold_full;
  assign up.data_ready = ready;
  assign accept        = up.data_valid & ready;

  assign last    = (cnt == LAST);
  assign shifted = shift_one(shf);

  // A held word moves into the shifter when idle, or on the enabled last bit
  // so the next word follows with no idle bit.
  assign take = hold_full & ((state == IDLE) | ((state == SHIFT) & en & last));

  assign word_done = (state == SHIFT) & en & last;

  feeder_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .take (take),
    .din  (up.data_in),
    .dout (hold_dat),
    .full (hold_full)
  );

  // Shifter FSM; x and x_valid are registered alongside the shifter so x is glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shf     <= '0;
      cnt     <= '0;
      x       <= IDLE_BIT;
      x_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hold_full) begin
            state   <= SHIFT;
            shf     <= hold_dat;
            cnt     <= '0;
            x       <= out_bit(hold_dat);
            x_valid <= 1'b1;
          end else begin
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
          end
        end
        SHIFT: begin
          if (en) begin
            if (!last) begin
              shf <= shifted;
              cnt <= cnt + 1'b1;
              x   <= out_bit(shifted);
            end else if (hold_full) begin
              shf     <= hold_dat;
              cnt     <= '0;
              x       <= out_bit(hold_dat);
              x_valid <= 1'b1;
            end else begin
              state   <= IDLE;
              cnt     <= '0;
              x       <= IDLE_BIT;
              x_valid <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          x       <= IDLE_BIT;
          x_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: MSB-first instance u0 and LSB-first instance u1.
module tb_serial_bit_feeder;

  logic clk = 1'b0;
  logic rst;
  logic en0, en1;
  logic x0, xv0, wd0;
  logic x1, xv1, wd1;

  always #5 clk = ~clk;

  serial_bit_feeder_if #(.WIDTH(8)) if0 ();
  serial_bit_feeder_if #(.WIDTH(8)) if1 ();

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u0 (
    .clk       (clk),
    .rst       (rst),
    .up        (if0.slave),
    .en        (en0),
    .x         (x0),
    .x_valid   (xv0),
    .word_done (wd0)
  );

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u1 (
    .clk       (clk),
    .rst       (rst),
    .up        (if1.slave),
    .en        (en1),
    .x         (x1),
    .x_valid   (xv1),
    .word_done (wd1)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]  src_q[$];
  logic        rdy_seen;
  logic [63:0] cap_x, cap_v, cap_d, cap_r;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Each step samples u0 (oldest sample ends up leftmost),
  // retires a word that was accepted at the previous edge, offers the next one,
  // and drives en low for step indices stall_lo..stall_hi.
  task automatic capture(input int n, input int stall_lo, input int stall_hi);
    cap_x = '0; cap_v = '0; cap_d = '0; cap_r = '0;
    for (int i = 0; i < n; i++) begin
      cap_x = {cap_x[62:0], x0};
      cap_v = {cap_v[62:0], xv0};
      cap_d = {cap_d[62:0], wd0};
      cap_r = {cap_r[62:0], if0.data_ready};
      if (if0.data_valid && rdy_seen) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        if0.data_valid = 1'b1;
        if0.data_in    = src_q[0];
      end else begin
        if0.data_valid = 1'b0;
      end
      rdy_seen = if0.data_ready;
      en0 = !(i >= stall_lo && i <= stall_hi);
      @(negedge clk);
    end
  endtask

  logic [2:0] hist;
  int         ycnt;

  initial begin
    rst = 1'b0;
    en0 = 1'b1;
    en1 = 1'b1;
    if0.data_valid = 1'b0; if0.data_in = '0;
    if1.data_valid = 1'b0; if1.data_in = '0;
    rdy_seen = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check_eq("rst_x",       64'(x0),             64'd0);
    check_eq("rst_x_valid", 64'(xv0),            64'd0);
    check_eq("rst_done",    64'(wd0),            64'd0);
    check_eq("rst_ready",   64'(if0.data_ready), 64'd0);
    rst = 1'b1;
    #1;
    check_eq("rel_ready",   64'(if0.data_ready), 64'd1);
    @(negedge clk);

    // Single word A5, MSB first; step 0 is the cycle before the accepting edge
    src_q = '{8'hA5};
    capture(12, 100, 100);
    check_eq("a5_x",    cap_x, 64'b001010010100);
    check_eq("a5_vld",  cap_v, 64'b001111111100);
    check_eq("a5_done", cap_d, 64'b000000000100);

    // A5, 5A, 3C streamed with valid held high: gapless 24 bits
    src_q = '{8'hA5, 8'h5A, 8'h3C};
    capture(27, 100, 100);
    check_eq("b2b_x",     cap_x, 64'b001010010101011010001111000);
    check_eq("b2b_vld",   cap_v, 64'b001111111111111111111111110);
    check_eq("b2b_done",  cap_d, 64'b000000000100000001000000010);
    check_eq("b2b_ready", cap_r, 64'b101000000010000000111111111);

    // A5 with en low for the three edges after the second bit appears
    src_q = '{8'hA5};
    capture(14, 3, 5);
    check_eq("stall_x",    cap_x, 64'b00100001001010);
    check_eq("stall_vld",  cap_v, 64'b00111111111110);
    check_eq("stall_done", cap_d, 64'b00000000000010);

    // Reset while bit 4 of FF is on x and 0F is held
    src_q = '{8'hFF, 8'h0F};
    capture(5, 100, 100);
    check_eq("mid_pre_x",   64'(x0),  64'd1);
    check_eq("mid_pre_vld", 64'(xv0), 64'd1);
    check_eq("mid_pre_rdy", 64'(if0.data_ready), 64'd0);
    rst = 1'b0;
    if0.data_valid = 1'b0;
    src_q.delete();
    rdy_seen = 1'b0;
    #1;
    check_eq("mid_x",     64'(x0),             64'd0);
    check_eq("mid_vld",   64'(xv0),            64'd0);
    check_eq("mid_done",  64'(wd0),            64'd0);
    check_eq("mid_ready", 64'(if0.data_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rel_ready", 64'(if0.data_ready), 64'd1);
    capture(12, 100, 100);
    check_eq("mid_after_x",   cap_x, 64'd0);
    check_eq("mid_after_vld", cap_v, 64'd0);

    // LSB first, 05, feeding a model 101 detector
    hist = 3'b000;
    ycnt = 0;
    if1.data_in    = 8'h05;
    if1.data_valid = 1'b1;
    @(negedge clk);
    if1.data_valid = 1'b0;
    cap_x = '0;
    cap_v = '0;
    for (int i = 0; i < 11; i++) begin
      cap_x = {cap_x[62:0], x1};
      cap_v = {cap_v[62:0], xv1};
      hist  = {hist[1:0], x1};
      if (hist == 3'b101) ycnt++;
      @(negedge clk);
    end
    check_eq("lsb_x",   cap_x, 64'b01010000000);
    check_eq("lsb_vld", cap_v, 64'b01111111100);
    check_eq("lsb_y",   64'(ycnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Upstream feeder for the serial pattern-detector stage: accepts parallel words over a valid/ready handshake and shifts them out one bit per enabled clock on `x`. `x` connects directly to the detector's `x` input. A one-entry holding register allows back-to-back words to stream with no idle bit between them. When no word is in flight, `x` is held at a fixed idle level so the detector sees a defined input on every clock.

## Interface
- `WIDTH`, 8: bits per word; legal range ≥ 2.
- `MSB_FIRST`, 1: 1 = bit `WIDTH-1` is sent first, 0 = bit 0 is sent first.
- `IDLE_BIT`, 0: level driven on `x` when no word is being shifted.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset).
- `data_in`  in  WIDTH  parallel word; sampled when the handshake fires.
- `data_valid`  in  1  `data_in` holds a word.
- `data_ready`  out  1  holding register is empty; equals `rst & ~hold_full`.
- `en`  in  1  shift enable; 0 stalls the shifter with `x` held.
- `x`  out  1  serial bit to the detector; registered.
- `x_valid`  out  1  `x` carries a data bit (not idle).
- `word_done`  out  1  one-cycle pulse while the last bit of a word is on `x` and `en` = 1.

## Operation
- Handshake: a transfer occurs on a rising edge where `data_valid & data_ready`. `data_in` is captured into the holding register and `hold_full` is set. `data_valid` is ignored while `data_ready` = 0.
- Shifter FSM, 2 states:
  - IDLE: `x` = `IDLE_BIT`, `x_valid` = 0. If `hold_full`, load the shifter from the holding register, clear `hold_full`, set `cnt` = 0, go to SHIFT. `en` is not required for this load.
  - SHIFT: `x` = current output bit, `x_valid` = 1. On an edge with `en` = 1 and `cnt` < `WIDTH-1`: shift by one toward the output end and increment `cnt`.
  - Last bit (`cnt` = `WIDTH-1`, `en` = 1), `hold_full` = 1: reload from the holding register, clear `hold_full`, set `cnt` = 0, stay in SHIFT. This gives a gapless stream.
  - Last bit, `hold_full` = 0: go to IDLE.
  - `en` = 0 in SHIFT: shifter, `cnt` and `x` hold; a handshake may still fill the holding register.
- Simultaneous events:
  - A handshake cannot coincide with a move from the holding register to the shifter, because `data_ready` is low whenever `hold_full` = 1.
  - A move and a new accept always occur on different edges.
- `word_done` = SHIFT & (`cnt` = `WIDTH-1`) & `en`, registered-path combinational; not asserted in IDLE.
- `cnt` width is `$clog2(WIDTH)` and never wraps past `WIDTH-1`.

## Timing
- Reset (`rst` = 0, asynchronous):
  - State = IDLE, `hold_full` = 0, `cnt` = 0, shifter cleared.
  - `x` = `IDLE_BIT`, `x_valid` = 0, `word_done` = 0, `data_ready` = 0.
  - `data_ready` rises to 1 combinationally with `rst` deassertion.
- Reset mid-word: the in-flight word and the held word are discarded. No partial word is resumed.
- Latency, with the handshake at edge k and the shifter idle:
  - Edge k+1: shifter loads.
  - First bit on `x` in the cycle after edge k+1.
  - With `en` held at 1, the last bit appears in the cycle after edge k+`WIDTH`.
- Throughput: one bit per enabled clock. A sustained source with `WIDTH` ≥ 2 sees no gaps, because `data_ready` returns high the cycle after a load and the next word is accepted within `WIDTH-1` cycles.
- Stalls: `x` and `x_valid` are stable for every cycle with `en` = 0.

## Structure
- Shared package `feeder_pkg` contains:
  - state enum `feeder_state_t` {IDLE, SHIFT};
  - `FEEDER_DEFAULT_WIDTH` = 8;
  - `FEEDER_IDLE_BIT` = 0.
- Sub-module `feeder_hold_reg`: one-entry register with load/take/full signals, WIDTH-parameterised. The FSM and shifter live in the top module.

## Test plan
- Reset, then `data_in` = 8'hA5 accepted at edge k, `en` = 1, MSB_FIRST = 1 → `x` = 1,0,1,0,0,1,0,1 in cycles k+1..k+8. `x_valid` = 1 for exactly 8 cycles. `word_done` in cycle k+8. `x` = 0 afterward.
- 8'hA5 then 8'h5A offered back-to-back with `data_valid` held high → 16 consecutive `x_valid` cycles, no gap, `x` = 10100101 01011010. Two `word_done` pulses, 8 cycles apart.
- 8'hA5 with `en` = 0 during cycles k+3..k+5 → `x` holds 0 (bit 2) for those 3 cycles. Sequence resumes unchanged, and `word_done` is delayed by 3 cycles.
- `rst` asserted during bit 4 of 8'hFF, with 8'h0F held → `x` = 0 and `x_valid` = 0 immediately. After release, `data_ready` = 1 and no bits of either word are emitted.
- MSB_FIRST = 0, 8'h05 → `x` = 1,0,1,0,0,0,0,0. Downstream 101 detector asserts `y` exactly once.
- `data_valid` = 1 while `hold_full` = 1 and the shifter is busy → `data_ready` = 0. The held word is unchanged, and the new word is accepted only after the reload edge.
